// File: rtl/multi_cycle_ctl_pkg.sv
// multi_cycle_ctl_pkg: state codes, opcodes and datapath select encodings
// shared by the multi-cycle controller and its output decoder.
package multi_cycle_ctl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        RTYPEWB = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

endpackage

// File: rtl/multi_cycle_ctl_dec.sv
// multi_cycle_ctl_dec: Moore output decode of the controller state; only the
// fetch strobes and the store completion are qualified by memory readiness.
module multi_cycle_ctl_dec
    import multi_cycle_ctl_pkg::*;
(
    input  state_t     state,
    input  logic       ready,
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.pc_write  = ready;
                ctrl.ir_write  = ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                ctrl.illegal   = !op_legal(op);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            RTYPEWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctl.sv
// multi_cycle_ctl: multi-cycle MIPS-style control FSM (state register and
// next-state logic). Define MULTI_CYCLE_CTL_MEM_WAIT_EN to honour mem_ready.
module multi_cycle_ctl
    import multi_cycle_ctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       instr_done,
    output logic       illegal,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state
);

    state_t cur, nxt;
    logic   ready;
    ctrl_t  ctrl;

`ifdef MULTI_CYCLE_CTL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    // memory always completes in one cycle; the port is kept but has no effect
    assign ready = mem_ready | 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            IDLE:    nxt = FETCH;
            FETCH:   nxt = ready ? DECODE : FETCH;
            DECODE:  nxt = (op == OP_R)                   ? EXEC   :
                           (op == OP_LW || op == OP_SW)   ? MEMADR :
                           (op == OP_BEQ)                 ? BRANCH :
                           (op == OP_J)                   ? JUMP   : FETCH;
            MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = ready ? MEMWB : MEMRD;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = ready ? FETCH : MEMWR;
            EXEC:    nxt = RTYPEWB;
            RTYPEWB: nxt = FETCH;
            BRANCH:  nxt = FETCH;
            JUMP:    nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    multi_cycle_ctl_dec u_dec (
        .state (cur),
        .ready (ready),
        .op    (op),
        .ctrl  (ctrl)
    );

    assign state       = cur;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign instr_done  = ctrl.instr_done;
    assign illegal     = ctrl.illegal;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;

endmodule

// File: tb/tb_multi_cycle_ctl.sv
// tb_multi_cycle_ctl: randomized instruction stream against a per-instruction
// phase model of the multi-cycle controller, plus directed reset and opcode cases.
module tb_multi_cycle_ctl;

`ifdef MULTI_CYCLE_CTL_MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst, instr_done, illegal;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;
    int         total = 0;
    int         fails = 0;
    int         done_seen;

    always #5 clk = ~clk;

    multi_cycle_ctl dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .instr_done(instr_done), .illegal(illegal),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .state(state)
    );

    wire [17:0] outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                        MemtoReg, ALUSrcA, RegWrite, RegDst, instr_done, illegal,
                        ALUOp, ALUSrcB, PCSource};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    endfunction

    // states visited by one instruction, FETCH first
    function automatic q_t phases(input logic [5:0] o);
        case (o)
            6'b000000: return '{1, 2, 7, 8};
            6'b100011: return '{1, 2, 3, 4, 5};
            6'b101011: return '{1, 2, 3, 6};
            6'b000100: return '{1, 2, 9};
            6'b000010: return '{1, 2, 10};
            default:   return '{1, 2};
        endcase
    endfunction

    // expected control outputs for a state, the effective readiness and op
    function automatic logic [17:0] model(input int s, input logic r, input logic [5:0] o);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mw = 0, irw = 0;
        logic m2r = 0, asa = 0, rw = 0, rdst = 0, done = 0, ill = 0;
        logic [1:0] aop = 0, srcb = 0, pcs = 0;
        case (s)
            1:  begin mrd = 1; srcb = 2'b01; pcw = r; irw = r; end
            2:  begin srcb = 2'b11; ill = !legal(o); end
            3:  begin asa = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin m2r = 1; rw = 1; done = 1; end
            6:  begin mw = 1; iord = 1; done = r; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rdst = 1; rw = 1; done = 1; end
            9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            10: begin pcw = 1; pcs = 2'b10; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mw, irw, m2r, asa, rw, rdst, done, ill, aop, srcb, pcs};
    endfunction

    task automatic cycle(input int s, input logic r, input logic [5:0] ov);
        @(negedge clk);
        mem_ready = r;
        op = ov;
        #1;
        chk("state", 32'(state), 32'(s));
        chk("outputs", 32'(outs), 32'(model(s, WAIT ? r : 1'b1, ov)));
        if (instr_done) done_seen++;
    endtask

    // fw/mw: cycles of mem_ready low in FETCH and in MEMRD/MEMWR
    task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
        q_t p = phases(o);
        done_seen = 0;
        foreach (p[i]) begin
            int s = p[i];
            logic [5:0] ov = (s == 2 || s == 3) ? o : 6'($urandom);
            if (WAIT && (s == 1 || s == 4 || s == 6)) begin
                repeat (s == 1 ? fw : mw) cycle(s, 1'b0, ov);
                cycle(s, 1'b1, ov);
            end else begin
                cycle(s, 1'($urandom), ov);
            end
        end
        chk("done_count", 32'(done_seen), legal(o) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [5:0] ops [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        rst = 1'b1;
        mem_ready = 1'b1;
        op = 6'b100011;
        #3;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outputs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_outputs", 32'(outs), 32'd0);

        run_instr(6'b100011, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b100011, 2, 1);
        run_instr(6'b000000, 1, 0);

        // asynchronous reset in the middle of a load
        cycle(1, 1'b1, 6'b100011);
        cycle(2, 1'b1, 6'b100011);
        cycle(3, 1'b1, 6'b100011);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("memrd_reached", 32'(state), 32'd4);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_outputs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("held_idle", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        chk("first_fetch", 32'(state), 32'd1);

        repeat (80) begin
            int k = $urandom_range(0, 5);
            logic [5:0] o = (k == 5) ? 6'($urandom) : ops[k];
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
